// File: rtl/mdu_issue_ctrl.sv
// rtl/mdu_issue_ctrl.sv - E-stage issue/latency sequencer for the multiply/divide unit
module mdu_issue_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       e_valid,
  input  logic [3:0] e_op,
  input  logic       d_is_mdu,
  output logic       mdu_start,
  output logic [3:0] mdu_ctr,
  output logic       busy,
  output logic       commit,
  output logic       mt_we,
  output logic       mt_hi,
  output logic       stall
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             commit_q, commit_nxt;
  logic             is_md, is_mt, is_mult;

  assign is_md   = (e_op >= 4'd1) && (e_op <= 4'd4);
  assign is_mt   = (e_op == 4'd7) || (e_op == 4'd8);
  assign is_mult = (e_op == 4'd1) || (e_op == 4'd2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      commit_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      commit_q <= commit_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    commit_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (mdu_start) begin
          state_nxt = RUN;
          cnt_nxt   = is_mult ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
        end
      end
      RUN: begin
        // A flush never cancels an in-flight op; it always counts down to commit.
        if (cnt == CNT_W'(1)) begin
          state_nxt  = IDLE;
          cnt_nxt    = '0;
          commit_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Every output is forced low while reset is asserted, combinational ones included.
  assign commit    = reset && commit_q;
  assign busy      = reset && (state == RUN);
  assign mdu_start = reset && (state == IDLE) && !commit_q && e_valid && is_md && !req;
  assign mt_we     = reset && e_valid && is_mt && !req;
  assign mt_hi     = reset && (e_op == 4'd7);
  assign mdu_ctr   = (mdu_start || mt_we) ? e_op : 4'd0;
  assign stall     = reset && d_is_mdu && (mdu_start || busy || commit);

endmodule
